// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single regfile write port (decoder5_32 + data).
// Ports: clk, reset_n; req_valid/addr/data in, req_ready out; wr_stall in;
// wr_en/wr_addr/wr_data registered port drive; last_grant one-hot debug.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 64,
  parameter int AW   = 5,
  parameter int ZREG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             wr_stall,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic [NREQ-1:0]  last_grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic            found;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  int              j;

  // Search from ptr+1 with wrap; first valid requester wins.
  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[PW'(j)]) begin
        found        = 1'b1;
        gnt[PW'(j)]  = 1'b1;
        gidx         = PW'(j);
      end
    end
    if (!reset_n || wr_stall) gnt = '0;
  end

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Zero-register writes still take the grant and move the pointer,
  // they just never raise the enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= '0;
      ptr        <= PW'(NREQ - 1);
    end else if (xfer) begin
      wr_en      <= (sel_addr != AW'(ZREG));
      wr_addr    <= sel_addr;
      wr_data    <= sel_data;
      last_grant <= gnt;
      ptr        <= gidx;
    end else begin
      wr_en      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter (NREQ=3, DW=64, AW=5).
// Table of per-cycle records plus hand sequences for reset corners.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 64;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NREQ-1:0]   last_grant;

  regfile_write_arbiter #(
    .NREQ(NREQ), .DW(DW), .AW(AW), .ZREG(31)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   valid;
    logic         stall;
    logic [14:0]  a;
    logic [191:0] d;
    logic [2:0]   rdy;
    logic         en;
    logic [4:0]   waddr;
    logic [63:0]  wdata;
    logic [2:0]   lg;
  } vec_t;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h5A5A_0000_FFFF_A5A5;
  localparam logic [14:0] A  = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] A3 = {5'd3, 5'd31, 5'd1};
  localparam logic [14:0] A5 = {5'd5, 5'd2, 5'd5};
  localparam logic [191:0] DN = {D2, D1, D0};
  localparam logic [191:0] D3 = {D2, 64'hDEAD, D0};
  localparam logic [191:0] D5 = {64'h2, D1, 64'h1};

  vec_t        tbl[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] sb[32];

  always @(negedge clk) begin
    if (wr_en === 1'b1) sb[wr_addr] = wr_data;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic s,
                     input logic [14:0] a, input logic [191:0] d,
                     input logic [2:0] r, input logic e,
                     input logic [4:0] wa, input logic [63:0] wd,
                     input logic [2:0] lg);
    vec_t t;
    t.valid = v;  t.stall = s; t.a = a; t.d = d;
    t.rdy = r;    t.en = e;    t.waddr = wa;
    t.wdata = wd; t.lg = lg;
    tbl.push_back(t);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sb[i] = '0;
    reset_n   = 1'b0;
    req_valid = 3'b111;
    wr_stall  = 1'b0;
    req_addr  = A;
    req_data  = DN;

    repeat (3) begin
      @(negedge clk);
      nvec++;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_en", 64'(wr_en), 64'd0);
      chk("rst_addr", 64'(wr_addr), 64'd0);
      chk("rst_data", wr_data, 64'd0);
      chk("rst_lg", 64'(last_grant), 64'd0);
    end

    // round robin, all valid
    for (int r = 0; r < 2; r++) begin
      add(3'b111, 0, A, DN, 3'b001, 1, 5'd1, D0, 3'b001);
      add(3'b111, 0, A, DN, 3'b010, 1, 5'd2, D1, 3'b010);
      add(3'b111, 0, A, DN, 3'b100, 1, 5'd3, D2, 3'b100);
    end
    // stall
    for (int r = 0; r < 3; r++)
      add(3'b111, 1, A, DN, 3'b000, 0, 5'd3, D2, 3'b100);
    add(3'b111, 0, A, DN, 3'b001, 1, 5'd1, D0, 3'b001);
    // zero register write
    add(3'b010, 0, A3, D3, 3'b010, 0, 5'd31, 64'hDEAD, 3'b010);
    add(3'b111, 0, A, DN, 3'b100, 1, 5'd3, D2, 3'b100);
    add(3'b000, 0, A, DN, 3'b000, 0, 5'd3, D2, 3'b100);
    // same-address serialisation
    add(3'b101, 0, A5, D5, 3'b001, 1, 5'd5, 64'h1, 3'b001);
    add(3'b100, 0, A5, D5, 3'b100, 1, 5'd5, 64'h2, 3'b100);
    add(3'b000, 0, A5, D5, 3'b000, 0, 5'd5, 64'h2, 3'b100);

    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].valid;
      wr_stall  = tbl[i].stall;
      req_addr  = tbl[i].a;
      req_data  = tbl[i].d;
      #3;
      nvec++;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), 64'(wr_en), 64'(tbl[i].en));
      chk($sformatf("v%0d_addr", i), 64'(wr_addr), 64'(tbl[i].waddr));
      chk($sformatf("v%0d_data", i), wr_data, tbl[i].wdata);
      chk($sformatf("v%0d_lg", i), 64'(last_grant), 64'(tbl[i].lg));
    end

    // reset between grant edge and write cycle
    req_valid = 3'b111;
    req_addr  = A;
    req_data  = DN;
    #3;
    nvec++;
    chk("r6_ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    chk("r6_en_pre", 64'(wr_en), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    chk("r6_en_async", 64'(wr_en), 64'd0);
    chk("r6_addr", 64'(wr_addr), 64'd0);
    chk("r6_data", wr_data, 64'd0);
    chk("r6_lg", 64'(last_grant), 64'd0);
    chk("r6_ready_rst", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("r6_hold_ready", 64'(req_ready), 64'd0);
    chk("r6_hold_en", 64'(wr_en), 64'd0);
    #1 reset_n = 1'b1;
    #1;
    nvec++;
    chk("r6_ptr_ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    chk("r6_en_post", 64'(wr_en), 64'd1);
    chk("r6_addr_post", 64'(wr_addr), 64'd1);
    chk("r6_data_post", wr_data, D0);
    chk("r6_lg_post", 64'(last_grant), 64'b001);

    req_valid = 3'b000;
    @(negedge clk);
    #1;
    nvec++;
    chk("sb_r5", sb[5], 64'h2);
    chk("sb_r31", sb[31], 64'h0);
    chk("sb_r1", sb[1], D0);
    chk("sb_r3", sb[3], D2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
